// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start / 8 data / optional parity / stop bits.
// Optional build macro UART_TX_STOP2_EN selects two stop bits instead of one.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  SER_DATA,
  input  logic                  SER_DONE,
  output logic                  SER_EN,
  output logic [DATA_WIDTH-1:0] SER_P_DATA,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // DATA is abandoned on its (DATA_WIDTH+1)th cycle if the Serializer never flags done
  localparam logic [3:0] WD_LAST = 4'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [3:0]            wd_cnt_q, wd_cnt_d;
`ifdef UART_TX_STOP2_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      wd_cnt_q  <= '0;
`ifdef UART_TX_STOP2_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      wd_cnt_q  <= wd_cnt_d;
`ifdef UART_TX_STOP2_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    wd_cnt_d  = wd_cnt_q;
`ifdef UART_TX_STOP2_EN
    stop_cnt_d = stop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        wd_cnt_d = '0;
        state_d  = DATA;
      end
      DATA: begin
        if (SER_DONE) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = STOP;
        end else begin
          wd_cnt_d = wd_cnt_q + 4'd1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
`ifdef UART_TX_STOP2_EN
        if (stop_cnt_q) begin
          state_d = IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef UART_TX_STOP2_EN
    if ((state_d == STOP) && (state_q != STOP)) begin
      stop_cnt_d = 1'b0;
    end
`endif
  end

  // SER_EN drops in the done cycle so the Serializer does not reload mid-frame
  always_comb begin
    SER_EN = 1'b0;
    TX_OUT = 1'b1;
    case (state_q)
      IDLE: begin
        TX_OUT = 1'b1;
      end
      START: begin
        SER_EN = 1'b1;
        TX_OUT = 1'b0;
      end
      DATA: begin
        SER_EN = ~SER_DONE;
        TX_OUT = SER_DATA;
      end
      PARITY: begin
        TX_OUT = par_bit_q;
      end
      STOP: begin
        TX_OUT = 1'b1;
      end
      default: begin
        TX_OUT = 1'b1;
      end
    endcase
  end

  assign BUSY       = (state_q != IDLE);
  assign SER_P_DATA = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural Serializer and a
// scoreboard of expected line bits; honours UART_TX_STOP2_EN when defined.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       SER_DATA;
  logic       SER_DONE;
  logic       SER_EN;
  logic [7:0] SER_P_DATA;
  logic       TX_OUT;
  logic       BUSY;

  int compared = 0;
  int mismatched = 0;
  bit exp_q[$];

  logic [7:0] ser_sh;
  logic [3:0] ser_cnt;
  logic       ser_act;
  logic       ser_mute = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .SER_DATA   (SER_DATA),
    .SER_DONE   (SER_DONE),
    .SER_EN     (SER_EN),
    .SER_P_DATA (SER_P_DATA),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  // Serializer: loads on the first enabled edge, then shifts LSB-first
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_sh  <= 8'h00;
      ser_cnt <= 4'd0;
      ser_act <= 1'b0;
    end else if (SER_EN) begin
      if (!ser_act) begin
        ser_sh  <= SER_P_DATA;
        ser_cnt <= 4'd0;
        ser_act <= 1'b1;
      end else begin
        ser_sh  <= {1'b0, ser_sh[7:1]};
        ser_cnt <= ser_cnt + 4'd1;
      end
    end else begin
      ser_act <= 1'b0;
    end
  end

  assign SER_DATA = ser_sh[0];
  assign SER_DONE = ser_act && (ser_cnt == 4'd7) && !ser_mute;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request and pushes the line bits the frame must produce
  task automatic applyStimulus(input logic [7:0] d, input logic pen, input logic ptyp,
                               input logic mute);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
    ser_mute   = mute;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (mute) exp_q.push_back(1'b0);
    else if (pen) exp_q.push_back((^d) ^ ptyp);
    exp_q.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
    exp_q.push_back(1'b1);
`endif
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge of the first idle cycle
  task automatic playFrame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input int drop_at, input int rst_at, input logic mute);
    int  idx;
    bit  e;
    bit  did_rst;
    idx = 0;
    did_rst = 1'b0;
    applyStimulus(d, pen, ptyp, mute);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    PAR_EN  = ~pen;
    PAR_TYP = ~ptyp;
    P_DATA  = ~d;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("tx_%02h_c%0d", d, idx), {7'd0, TX_OUT}, {7'd0, e});
      checkOutput($sformatf("busy_%02h_c%0d", d, idx), {7'd0, BUSY}, 8'd1);
      checkOutput($sformatf("seren_%02h_c%0d", d, idx), {7'd0, SER_EN},
                  {7'd0, (idx < 8) || (mute && idx < 10)});
      checkOutput($sformatf("spdata_%02h_c%0d", d, idx), SER_P_DATA, d);
      if (idx == rst_at) begin
        RST = 1'b1;
        #1;
        checkOutput("rst_tx", {7'd0, TX_OUT}, 8'd1);
        checkOutput("rst_busy", {7'd0, BUSY}, 8'd0);
        checkOutput("rst_seren", {7'd0, SER_EN}, 8'd0);
        checkOutput("rst_spdata", SER_P_DATA, 8'h00);
        exp_q.delete();
        did_rst = 1'b1;
      end else begin
        if (idx == drop_at) begin
          DATA_VALID = 1'b1;
          P_DATA     = 8'hFF;
        end else begin
          DATA_VALID = 1'b0;
        end
        idx++;
        @(negedge CLK);
      end
    end
    if (did_rst) begin
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    ser_mute   = 1'b0;
    checkOutput($sformatf("idle_tx_%02h", d), {7'd0, TX_OUT}, 8'd1);
    checkOutput($sformatf("idle_busy_%02h", d), {7'd0, BUSY}, 8'd0);
    checkOutput($sformatf("idle_seren_%02h", d), {7'd0, SER_EN}, 8'd0);
  endtask

  initial begin
    $display("[TB] start");
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("reset_tx", {7'd0, TX_OUT}, 8'd1);
    checkOutput("reset_busy", {7'd0, BUSY}, 8'd0);
    checkOutput("reset_spdata", SER_P_DATA, 8'h00);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("idle_tx_%0d", i), {7'd0, TX_OUT}, 8'd1);
      checkOutput($sformatf("idle_busy_%0d", i), {7'd0, BUSY}, 8'd0);
      checkOutput($sformatf("idle_seren_%0d", i), {7'd0, SER_EN}, 8'd0);
    end

    $display("[TB] no parity 0xA5");
    playFrame(8'hA5, 1'b0, 1'b0, -1, -1, 1'b0);
    @(negedge CLK);
    $display("[TB] even parity 0xA5");
    playFrame(8'hA5, 1'b1, 1'b0, -1, -1, 1'b0);
    @(negedge CLK);
    $display("[TB] odd parity 0xA5");
    playFrame(8'hA5, 1'b1, 1'b1, -1, -1, 1'b0);
    @(negedge CLK);

    $display("[TB] busy drop then back-to-back");
    playFrame(8'h3C, 1'b0, 1'b0, 3, -1, 1'b0);
    playFrame(8'h0F, 1'b0, 1'b0, -1, -1, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("post_b2b_busy", {7'd0, BUSY}, 8'd0);
    end

    $display("[TB] reset mid-frame");
    playFrame(8'h55, 1'b0, 1'b0, -1, 4, 1'b0);
    playFrame(8'h81, 1'b1, 1'b0, -1, -1, 1'b0);
    @(negedge CLK);

    $display("[TB] watchdog without serializer done");
    playFrame(8'hA5, 1'b1, 1'b0, -1, -1, 1'b1);
    @(negedge CLK);
    playFrame(8'hC3, 1'b0, 1'b1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
